linebuf_scheduler: RTL and testbench



---
 rtl/lb_pkg.sv | 21 ++
 rtl/lb_rot3.sv | 30 +++
 rtl/linebuf_scheduler.sv | 157 +++++++++++++++
 tb/tb_linebuf_scheduler.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/lb_pkg.sv
// Shared types for the 3-line buffer scheduler.
// FSM states, buffer-select type and mod-3 helper.
package lb_pkg;

  localparam int NUM_LINES = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_FILL,
    S_RUN,
    S_DONE
  } lb_state_e;

  typedef logic [1:0] buf_sel_t;

  function automatic buf_sel_t inc3(buf_sel_t s);
    return (s == buf_sel_t'(NUM_LINES - 1)) ? '0 : s + 2'd1;
  endfunction

endpackage

// File: rtl/lb_rot3.sv
// Mod-3 line-buffer rotator.
// Ports: clk, rst, i_clr, i_adv -> o_wr_sel, o_rd_old, o_rd_mid.
module lb_rot3
  import lb_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     i_clr,
  input  logic     i_adv,
  output buf_sel_t o_wr_sel,
  output buf_sel_t o_rd_old,
  output buf_sel_t o_rd_mid
);

  buf_sel_t r_sel;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_sel <= '0;
    end else if (i_adv) begin
      r_sel <= inc3(r_sel);
    end
  end

  // buffer after the write target is the oldest line
  assign o_wr_sel = r_sel;
  assign o_rd_old = inc3(r_sel);
  assign o_rd_mid = inc3(inc3(r_sel));

endmodule

// File: rtl/linebuf_scheduler.sv
// Sequencer for the 3-line buffer feeding a 3x3 window.
// In: clk, rst, enable, pixel strobes. Out: buffer ctl, window quals, coords, status.
module linebuf_scheduler
  import lb_pkg::*;
#(
  parameter int H_ADDR = 1280,
  parameter int V_ADDR = 720,
  parameter int ADDR_W = 11,
  parameter int CNT_W  = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              pixel_stream_valid,
  input  logic              h_start,
  input  logic              h_end,
  input  logic              v_start,
  input  logic              v_end,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [1:0]        wr_sel,
  output logic [1:0]        rd_sel_old,
  output logic [1:0]        rd_sel_mid,
  output logic              win_valid,
  output logic              border,
  output logic [CNT_W-1:0]  x_cnt,
  output logic [CNT_W-1:0]  y_cnt,
  output logic              busy,
  output logic              frame_done,
  output logic              line_err,
  output logic              err_sticky
);

  localparam logic [CNT_W-1:0] X_LAST = CNT_W'(H_ADDR - 1);
  localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(V_ADDR - 1);

  lb_state_e        r_state, w_state_n;
  logic [CNT_W-1:0] r_x, r_y, w_x_n, w_y_n;
  logic             r_fd, r_le, r_st;
  logic             w_fd_n, w_le_n, w_err;
  logic             w_adv, w_clr;
  logic             w_v, w_last, w_bad;

  assign w_v    = pixel_stream_valid;
  assign w_last = (r_x == X_LAST);

  // any framing violation on a valid pixel
  assign w_bad = w_v & ((h_end & ~w_last)
               | (~h_end & w_last)
               | v_start
               | (v_end & ((r_y != Y_LAST) | ~h_end))
               | (h_start & (r_x != '0)));

  always_comb begin
    w_state_n = r_state;
    w_x_n     = r_x;
    w_y_n     = r_y;
    w_adv     = 1'b0;
    w_clr     = 1'b0;
    w_fd_n    = 1'b0;
    w_le_n    = 1'b0;
    w_err     = 1'b0;
    wr_en     = 1'b0;
    win_valid = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_x_n = '0;
        w_y_n = '0;
        w_clr = 1'b1;
        if (enable) w_state_n = S_WAIT;
      end
      S_WAIT: begin
        w_x_n = '0;
        w_y_n = '0;
        w_clr = 1'b1;
        if (!enable) begin
          w_state_n = S_IDLE;
        end else if (w_v && v_start) begin
          wr_en     = 1'b1;
          w_x_n     = CNT_W'(1);
          w_state_n = S_FILL;
        end
      end
      S_FILL, S_RUN: begin
        wr_en     = w_v;
        win_valid = w_v & (r_state == S_RUN);
        if (w_bad) begin
          w_err     = 1'b1;
          w_le_n    = 1'b1;
          w_x_n     = '0;
          w_y_n     = '0;
          w_clr     = 1'b1;
          w_state_n = S_WAIT;
        end else if (w_v) begin
          if (h_end) begin
            w_x_n = '0;
            w_y_n = r_y + CNT_W'(1);
            w_adv = 1'b1;
            if (v_end) begin
              w_fd_n    = 1'b1;
              w_state_n = S_DONE;
            end else if (r_state == S_FILL && r_y == CNT_W'(1)) begin
              w_state_n = S_RUN;
            end
          end else begin
            w_x_n = r_x + CNT_W'(1);
          end
        end
      end
      S_DONE: begin
        w_x_n     = '0;
        w_y_n     = '0;
        w_clr     = 1'b1;
        w_state_n = enable ? S_WAIT : S_IDLE;
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_fd    <= 1'b0;
      r_le    <= 1'b0;
      r_st    <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_x     <= w_x_n;
      r_y     <= w_y_n;
      r_fd    <= w_fd_n;
      r_le    <= w_le_n;
      r_st    <= enable & (r_st | w_err);
    end
  end

  lb_rot3 u_rot (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_clr),
    .i_adv    (w_adv),
    .o_wr_sel (wr_sel),
    .o_rd_old (rd_sel_old),
    .o_rd_mid (rd_sel_mid)
  );

  assign wr_addr    = r_x[ADDR_W-1:0];
  assign border     = win_valid & ((r_x == '0) | w_last);
  assign x_cnt      = r_x;
  assign y_cnt      = r_y;
  assign busy       = (r_state == S_FILL) | (r_state == S_RUN);
  assign frame_done = r_fd;
  assign line_err   = r_le;
  assign err_sticky = r_st;

endmodule

// File: tb/tb_linebuf_scheduler.sv
// Randomized bench for linebuf_scheduler (8x6 frame).
// Frame-level reference model; clean and faulty frames.
module tb_linebuf_scheduler;

  localparam int H  = 8;
  localparam int V  = 6;
  localparam int AW = 3;
  localparam int CW = 12;

  logic          clk = 1'b0;
  logic          rst, enable, v, hs, he, vs, ve;
  logic          wr_en, win_valid, border, busy;
  logic          frame_done, line_err, err_sticky;
  logic [AW-1:0] wr_addr;
  logic [1:0]    wr_sel, rd_sel_old, rd_sel_mid;
  logic [CW-1:0] x_cnt, y_cnt;

  always #5 clk = ~clk;

  linebuf_scheduler #(
    .H_ADDR (H),
    .V_ADDR (V),
    .ADDR_W (AW),
    .CNT_W  (CW)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .enable             (enable),
    .pixel_stream_valid (v),
    .h_start            (hs),
    .h_end              (he),
    .v_start            (vs),
    .v_end              (ve),
    .wr_en              (wr_en),
    .wr_addr            (wr_addr),
    .wr_sel             (wr_sel),
    .rd_sel_old         (rd_sel_old),
    .rd_sel_mid         (rd_sel_mid),
    .win_valid          (win_valid),
    .border             (border),
    .x_cnt              (x_cnt),
    .y_cnt              (y_cnt),
    .busy               (busy),
    .frame_done         (frame_done),
    .line_err           (line_err),
    .err_sticky         (err_sticky)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  // model: mode 0 off, 1 waiting for frame, 2 in frame, 3 frame end
  int m_mode, m_x, m_ln;
  bit m_fd, m_le, m_st;
  int n_win, n_wr, n_fd;

  task automatic compare();
    bit act, e_wr, e_win, e_bor;
    act   = (m_mode == 2);
    e_wr  = (m_mode == 1 && enable && v && vs) || (act && v);
    e_win = act && m_ln >= 2 && v;
    e_bor = e_win && (m_x == 0 || m_x == H - 1);
    chk("wr_en", wr_en, e_wr);
    chk("wr_addr", wr_addr, m_x % H);
    chk("win_valid", win_valid, e_win);
    chk("border", border, e_bor);
    chk("x_cnt", x_cnt, m_x);
    chk("busy", busy, act);
    chk("frame_done", frame_done, m_fd);
    chk("line_err", line_err, m_le);
    chk("err_sticky", err_sticky, m_st);
    if (m_mode != 3) begin
      chk("y_cnt", y_cnt, m_ln);
      chk("wr_sel", wr_sel, m_ln % 3);
      chk("rd_old", rd_sel_old, (m_ln + 1) % 3);
      chk("rd_mid", rd_sel_mid, (m_ln + 2) % 3);
    end
    if (win_valid) n_win++;
    if (wr_en) n_wr++;
    if (frame_done) n_fd++;
  endtask

  task automatic model_step();
    bit err, bad;
    err = 0;
    if (rst) begin
      m_mode = 0; m_x = 0; m_ln = 0;
      m_fd = 0; m_le = 0; m_st = 0;
      return;
    end
    m_fd = 0;
    m_le = 0;
    case (m_mode)
      0: if (enable) m_mode = 1;
      1: begin
        if (!enable) m_mode = 0;
        else if (v && vs) begin
          m_mode = 2; m_x = 1; m_ln = 0;
        end
      end
      2: if (v) begin
        bad = (he && m_x != H - 1) || (!he && m_x == H - 1) || vs
           || (ve && (m_ln != V - 1 || !he)) || (hs && m_x != 0);
        if (bad) begin
          err = 1; m_le = 1; m_mode = 1; m_x = 0; m_ln = 0;
        end else if (he) begin
          m_x = 0;
          m_ln++;
          if (ve) begin
            m_mode = 3; m_fd = 1;
          end
        end else begin
          m_x++;
        end
      end
      default: begin
        m_mode = enable ? 1 : 0; m_x = 0; m_ln = 0;
      end
    endcase
    m_st = enable ? (m_st | err) : 1'b0;
  endtask

  task automatic cycle(bit r, bit e, bit vv, bit h_s, bit h_e, bit v_s, bit v_e);
    @(negedge clk);
    rst = r; enable = e; v = vv;
    hs = h_s; he = h_e; vs = v_s; ve = v_e;
    #1 compare();
    @(posedge clk);
    model_step();
  endtask

  // invalid cycle with junk on the strobes
  task automatic idle(bit e);
    cycle(0, e, 0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
  endtask

  // kinds: 0 clean, 1 early h_end, 2 early v_start, 3 overrun,
  // 4 stray h_start, 5 early v_end, 6 rst mid-frame, 7 enable drop
  task automatic send_frame(int kind);
    bit e, r, h_s, h_e, v_s, v_e;
    e = 1;
    n_win = 0; n_wr = 0; n_fd = 0;
    for (int l = 0; l < V; l++) begin
      for (int c = 0; c < H; c++) begin
        while ($urandom_range(0, 3) == 0) idle(e);
        h_s = (c == 0);
        h_e = (c == H - 1);
        v_s = (l == 0 && c == 0);
        v_e = (l == V - 1 && c == H - 1);
        r = 0;
        case (kind)
          1: if (l == 3 && c == 6) h_e = 1;
          2: if (l == 2 && c == 3) v_s = 1;
          3: if (l == 4 && c == 7) h_e = 0;
          4: if (l == 2 && c == 5) h_s = 1;
          5: if (l == 3 && c == 7) v_e = 1;
          6: if (l == 3 && c == 4) r = 1;
          7: if (l == 3 && c == 0) e = 0;
          default: ;
        endcase
        cycle(r, e, 1, h_s, h_e, v_s, v_e);
      end
    end
    repeat ($urandom_range(1, 3)) idle(e);
    if (kind == 0 || kind == 7) begin
      chk("win_count", n_win, 32);
      chk("wr_count", n_wr, 48);
      chk("fd_count", n_fd, 1);
    end else begin
      chk("fd_count_err", n_fd, 0);
    end
    if (kind == 7) begin
      cycle(0, 0, 1, 1, 0, 1, 0);
      repeat (2) idle(1);
    end
  endtask

  initial begin
    rst = 1; enable = 0; v = 0;
    hs = 0; he = 0; vs = 0; ve = 0;
    m_mode = 0; m_x = 0; m_ln = 0;
    m_fd = 0; m_le = 0; m_st = 0;
    repeat (2) @(posedge clk);
    cycle(0, 0, 0, 0, 0, 0, 0);
    repeat (2) idle(1);
    send_frame(0);
    send_frame(0);
    send_frame(1);
    send_frame(0);
    send_frame(2);
    send_frame(0);
    send_frame(6);
    send_frame(0);
    send_frame(7);
    send_frame(3);
    send_frame(4);
    send_frame(5);
    send_frame(0);
    for (int i = 0; i < 12; i++) send_frame($urandom_range(0, 7));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
